avalon_rom_agent: RTL

//  Parametrised Avalon-MM read agent: a word memory that serves instruction

---
 rtl/avalon_rom_agent.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/avalon_rom_agent.sv
// avalon_rom_agent
// Avalon-MM read-only word memory used as an instruction source for the Cpu.
// Reads are pipelined with a fixed return latency and a cap on outstanding
// requests. Waitrequest can be forced externally or injected periodically.
// A back-door port preloads programs.
//
// Words are stored XOR'd with DEFAULT_WORD. An array that powers up all-zero,
// such as FPGA block RAM or a simulator's zero-initialised state, therefore
// reads back as DEFAULT_WORD. No initialisation logic is needed, and a reset
// never touches the memory.

module avalon_rom_agent #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          LATENCY      = 1,
    parameter int          MAX_PENDING  = 4,
    parameter int          STALL_EVERY  = 0,
    parameter logic [31:0] DEFAULT_WORD = 32'h0000_0013
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [31:0]                        avm_address,
    input  logic                               avm_read,
    output logic                               avm_waitrequest,
    output logic [31:0]                        avm_readdata,
    output logic                               avm_readdatavalid,
    input  logic                               load_en,
    input  logic [31:0]                        load_addr,
    input  logic [31:0]                        load_data,
    input  logic                               stall_inject,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
    output logic                               err_misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int SW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

    logic [31:0]        mem_q [DEPTH_WORDS];

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [31:0]        data_q [LATENCY];
    logic [31:0]        data_d [LATENCY];
    logic [CW-1:0]      pending_q, pending_d;
    logic [SW-1:0]      stall_cnt_q, stall_cnt_d;
    logic               err_q, err_d;

    logic               periodic_stall;
    logic               accept;
    logic               retire;
    logic               rd_in_range;
    logic [AW-1:0]      rd_idx;
    logic [31:0]        rd_word;
    logic               mem_wr_en;
    logic [AW-1:0]      mem_wr_idx;
    logic [31:0]        mem_wr_data;
    logic               unused_load_lsbs;

    // Back-door addresses are word-aligned, so their byte-offset bits carry no information.
    assign unused_load_lsbs = ^load_addr[1:0];

    // Waitrequest comes from the full condition, the external stall and the periodic stall slot.
    always_comb begin
        periodic_stall = 1'b0;
        if (STALL_EVERY != 0) begin
            periodic_stall = (32'(stall_cnt_q) == 32'(STALL_EVERY - 1));
        end
        avm_waitrequest = (pending_q == CW'(MAX_PENDING)) | stall_inject | periodic_stall;
    end

    // Read side: acceptance, word lookup (old contents on a same-cycle load) and range check.
    always_comb begin
        accept      = rst & avm_read & ~avm_waitrequest;
        rd_idx      = avm_address[AW+1:2];
        rd_in_range = (avm_address[31:AW+2] == '0);
        rd_word     = DEFAULT_WORD;
        if (rd_in_range) begin
            rd_word = mem_q[rd_idx] ^ DEFAULT_WORD;
        end
    end

    // Back-door write decode; writes beyond the array are dropped.
    always_comb begin
        mem_wr_idx  = load_addr[AW+1:2];
        mem_wr_en   = load_en & (load_addr[31:AW+2] == '0);
        mem_wr_data = load_data ^ DEFAULT_WORD;
    end

    // Next state for the return pipeline, outstanding count, stall counter and error flag.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < LATENCY; i++) begin
            data_d[i] = data_q[i];
        end
        for (int i = LATENCY - 1; i > 0; i--) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
        valid_d[0] = accept;
        data_d[0]  = accept ? rd_word : 32'h0;

        retire    = valid_q[LATENCY-1];
        pending_d = pending_q;
        if (accept && !retire) begin
            pending_d = pending_q + CW'(1);
        end else if (!accept && retire) begin
            pending_d = pending_q - CW'(1);
        end

        stall_cnt_d = '0;
        if (STALL_EVERY > 1) begin
            if (32'(stall_cnt_q) != 32'(STALL_EVERY - 1)) begin
                stall_cnt_d = stall_cnt_q + SW'(1);
            end
        end

        err_d = err_q | (accept & (avm_address[1:0] != 2'b00));
    end

    // Control and pipeline registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
            pending_q   <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    // Memory array has no reset so that preloaded programs survive a reset.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            mem_q[mem_wr_idx] <= mem_wr_data;
        end
    end

    // Output stage: readdata is forced to zero whenever it is not valid.
    always_comb begin
        avm_readdatavalid = valid_q[LATENCY-1];
        avm_readdata      = valid_q[LATENCY-1] ? data_q[LATENCY-1] : 32'h0;
        pending_count     = pending_q;
        err_misaligned    = err_q;
    end

endmodule
